mapa_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the 8-way, 7-bit map selector (mapa0..mapa7 -> out[6:0]).
- Drives the selector's 3-bit sel and a one-hot column enable, so that each of the 8 display columns shows its map in turn.
- Inserts blanking between slots to prevent ghosting.
- Supports a hold mode that freezes the display on one chosen map.
- Sits between the game/top-level control logic and the map selector + LED matrix drivers.

---
 rtl/mapa_scan_ctrl_pkg.sv | 23 ++
 rtl/mapa_scan_ctrl_if.sv | 23 ++
 rtl/mapa_scan_ctrl_slot_timer.sv | 25 ++
 rtl/mapa_scan_ctrl.sv | 101 ++++++++++
 tb/tb_mapa_scan_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mapa_scan_ctrl_pkg.sv
// Shared constants, FSM state encoding and counter sizing for the map scan controller.
package mapa_scan_ctrl_pkg;

   localparam int NUM_MAPS = 8;
   localparam int MAP_W    = 7;
   localparam int SEL_W    = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_e;

   // Timer holds (duration - 1), so $clog2 of the largest duration is always wide enough.
   function automatic int cnt_width(input int clk_div, input int blank_cycles);
      int m;
      m = 2;
      if (clk_div > m) m = clk_div;
      if (blank_cycles > m) m = blank_cycles;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/mapa_scan_ctrl_if.sv
// Control/display bundle between the game logic, the scan controller and the map selector.
interface mapa_scan_ctrl_if;
   import mapa_scan_ctrl_pkg::*;

   logic                enable;
   logic                hold;
   logic [SEL_W-1:0]    hold_sel;
   logic [SEL_W-1:0]    sel;
   logic [NUM_MAPS-1:0] col_en;
   logic                blank;
   logic                frame_done;

   modport master (
      output enable, hold, hold_sel,
      input  sel, col_en, blank, frame_done
   );

   modport slave (
      input  enable, hold, hold_sel,
      output sel, col_en, blank, frame_done
   );

endinterface

// File: rtl/mapa_scan_ctrl_slot_timer.sv
// Loadable down-counter timing one BLANK or SHOW slot; done while the count sits at zero.
module mapa_scan_ctrl_slot_timer #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          done
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - CW'(1);
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/mapa_scan_ctrl.sv
// Time-multiplexing scan controller: walks sel/col_en through the 8 map columns with
// optional blanking between slots and a hold mode that freezes on one map.
module mapa_scan_ctrl
   import mapa_scan_ctrl_pkg::*;
#(
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic            clk,
   input  logic            reset,
   mapa_scan_ctrl_if.slave bus
);

   localparam int            CW         = cnt_width(CLK_DIV, BLANK_CYCLES);
   localparam logic [CW-1:0] SHOW_LD    = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] BLANK_LD   = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
   localparam state_e        SLOT_ENTRY = (BLANK_CYCLES == 0) ? SHOW : BLANK;
   localparam logic [CW-1:0] ENTRY_LD   = (BLANK_CYCLES == 0) ? SHOW_LD : BLANK_LD;

   state_e              state, state_nx;
   logic [SEL_W-1:0]    sel_q, sel_nx;
   logic [NUM_MAPS-1:0] col_en_q;
   logic                blank_q;
   logic                fd_q, fd_nx;
   logic                load;
   logic [CW-1:0]       load_val;
   logic                done;

   mapa_scan_ctrl_slot_timer #(.CW(CW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .done     (done)
   );

   // Next state, next index and timer reload; hold/hold_sel only matter at slot boundaries.
   always_comb begin
      state_nx = state;
      sel_nx   = sel_q;
      fd_nx    = 1'b0;
      load     = 1'b0;
      load_val = SHOW_LD;
      if (!bus.enable) begin
         state_nx = IDLE;
         sel_nx   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nx = SLOT_ENTRY;
               sel_nx   = bus.hold ? bus.hold_sel : '0;
               load     = 1'b1;
               load_val = ENTRY_LD;
            end
            BLANK: begin
               if (done) begin
                  state_nx = SHOW;
                  load     = 1'b1;
                  load_val = SHOW_LD;
               end
            end
            SHOW: begin
               if (done) begin
                  state_nx = SLOT_ENTRY;
                  sel_nx   = bus.hold ? bus.hold_sel : sel_q + SEL_W'(1);
                  fd_nx    = !bus.hold && (sel_q == SEL_W'(NUM_MAPS - 1));
                  load     = 1'b1;
                  load_val = ENTRY_LD;
               end
            end
            default: begin
               state_nx = IDLE;
               sel_nx   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they change on the same edge as the FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         sel_q    <= '0;
         col_en_q <= '0;
         blank_q  <= 1'b1;
         fd_q     <= 1'b0;
      end else begin
         state    <= state_nx;
         sel_q    <= sel_nx;
         col_en_q <= (state_nx == SHOW) ? (NUM_MAPS'(1) << sel_nx) : '0;
         blank_q  <= (state_nx != SHOW);
         fd_q     <= fd_nx;
      end
   end

   assign bus.sel        = sel_q;
   assign bus.col_en     = col_en_q;
   assign bus.blank      = blank_q;
   assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_mapa_scan_ctrl.sv
// Scoreboard bench: two controllers (CLK_DIV=4/BLANK=2 and CLK_DIV=1/BLANK=0) driven in lockstep
// against a slot-position model; a negedge monitor pops and compares every cycle.
module tb_mapa_scan_ctrl;
   import mapa_scan_ctrl_pkg::*;

   localparam int CA = 4, BA = 2;
   localparam int CB = 1, BB = 0;

   typedef struct packed {
      logic [2:0] sel;
      logic [7:0] col_en;
      logic       blank;
      logic       fd;
   } obs_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic drv_en = 1'b0;
   logic drv_hold = 1'b0;
   logic [2:0] drv_hsel = 3'd0;

   int vectors = 0;
   int miscompares = 0;

   obs_t qa[$];
   obs_t qb[$];

   int m_active[2];
   int m_sel[2];
   int m_pos[2];
   int m_fd[2];
   int m_blank[2] = '{BA, BB};
   int m_show[2]  = '{CA, CB};

   always #5 clk = ~clk;

   mapa_scan_ctrl_if ifa();
   mapa_scan_ctrl_if ifb();

   assign ifa.enable   = drv_en;
   assign ifa.hold     = drv_hold;
   assign ifa.hold_sel = drv_hsel;
   assign ifb.enable   = drv_en;
   assign ifb.hold     = drv_hold;
   assign ifb.hold_sel = drv_hsel;

   mapa_scan_ctrl #(.CLK_DIV(CA), .BLANK_CYCLES(BA)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
   mapa_scan_ctrl #(.CLK_DIV(CB), .BLANK_CYCLES(BB)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

   // Reference: a slot is BLANK_CYCLES dark positions followed by CLK_DIV lit positions.
   function automatic obs_t modelView(input int i);
      obs_t o;
      logic lit;
      lit      = (m_active[i] != 0) && (m_pos[i] >= m_blank[i]);
      o.sel    = 3'(m_sel[i]);
      o.col_en = lit ? (8'd1 << m_sel[i]) : 8'd0;
      o.blank  = !lit;
      o.fd     = (m_fd[i] != 0);
      return o;
   endfunction

   task automatic modelStep(input int i, input logic rst, input logic en, input logic h, input logic [2:0] hs);
      if (rst || !en) begin
         m_active[i] = 0; m_sel[i] = 0; m_pos[i] = 0; m_fd[i] = 0;
      end else if (m_active[i] == 0) begin
         m_active[i] = 1; m_sel[i] = h ? int'(hs) : 0; m_pos[i] = 0; m_fd[i] = 0;
      end else if (m_pos[i] == m_blank[i] + m_show[i] - 1) begin
         m_fd[i]  = (!h && m_sel[i] == 7) ? 1 : 0;
         m_sel[i] = h ? int'(hs) : (m_sel[i] + 1) % 8;
         m_pos[i] = 0;
      end else begin
         m_pos[i] = m_pos[i] + 1;
         m_fd[i]  = 0;
      end
   endtask

   task automatic checkOutput(input string name, input obs_t exp, input obs_t act);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s @%0t: got sel=%0d col_en=%h blank=%b frame_done=%b, expected sel=%0d col_en=%h blank=%b frame_done=%b",
                  name, $time, act.sel, act.col_en, act.blank, act.fd, exp.sel, exp.col_en, exp.blank, exp.fd);
      end
   endtask

   task automatic checkInvariant(input string name, input obs_t act);
      logic ok;
      ok = ((act.col_en == 8'd0) || $onehot(act.col_en)) &&
           ((act.col_en != 8'd0) == !act.blank) &&
           (act.blank || (act.col_en == (8'd1 << act.sel)));
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("[TB] FAIL %s @%0t: sel=%0d col_en=%h blank=%b violates one-hot/blank/sel agreement",
                  name, $time, act.sel, act.col_en, act.blank);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic h, input logic [2:0] hs);
      #2;
      drv_en = en; drv_hold = h; drv_hsel = hs;
      @(posedge clk);
      for (int i = 0; i < 2; i++) modelStep(i, reset, en, h, hs);
      qa.push_back(modelView(0));
      qb.push_back(modelView(1));
   endtask

   task automatic doReset();
      obs_t idle;
      obs_t act;
      idle = '{sel: 3'd0, col_en: 8'h00, blank: 1'b1, fd: 1'b0};
      #2;
      reset = 1'b1;
      qa.delete();
      qb.delete();
      for (int i = 0; i < 2; i++) modelStep(i, 1'b1, 1'b0, 1'b0, 3'd0);
      #1;
      act = {ifa.sel, ifa.col_en, ifa.blank, ifa.frame_done};
      checkOutput("reset_async_a", idle, act);
      act = {ifb.sel, ifb.col_en, ifb.blank, ifb.frame_done};
      checkOutput("reset_async_b", idle, act);
      qa.push_back(modelView(0));
      qb.push_back(modelView(1));
   endtask

   task automatic releaseReset();
      #1;
      reset = 1'b0;
   endtask

   // mode 0: instance A lit on target_sel; mode 1: instance A in a dark slot position.
   task automatic waitFor(input string name, input int mode, input int target_sel, input logic h, input logic [2:0] hs);
      int n;
      n = 0;
      while (!((mode == 0 && m_active[0] != 0 && m_pos[0] >= BA && m_sel[0] == target_sel) ||
               (mode == 1 && m_active[0] != 0 && m_pos[0] < BA)) && n < 200) begin
         applyStimulus(1'b1, h, hs);
         n++;
      end
      if (n >= 200) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s: condition not reached within 200 cycles (got timeout, expected reach)", name);
      end
   endtask

   // Monitor: every negedge, compare the DUT against the oldest queued expectation.
   always @(negedge clk) begin
      obs_t act;
      if (qa.size() > 0) begin
         act = {ifa.sel, ifa.col_en, ifa.blank, ifa.frame_done};
         checkOutput("scan_a", qa.pop_front(), act);
         checkInvariant("inv_a", act);
      end
      if (qb.size() > 0) begin
         act = {ifb.sel, ifb.col_en, ifb.blank, ifb.frame_done};
         checkOutput("scan_b", qb.pop_front(), act);
         checkInvariant("inv_b", act);
      end
   end

   initial begin
      logic en, h;
      logic [2:0] hs;
      for (int i = 0; i < 2; i++) modelStep(i, 1'b1, 1'b0, 1'b0, 3'd0);

      repeat (3) applyStimulus(1'b0, 1'b0, 3'd0);
      releaseReset();
      repeat (5) applyStimulus(1'b0, 1'b0, 3'd0);

      $display("[TB] full scan");
      repeat (110) applyStimulus(1'b1, 1'b0, 3'd0);

      $display("[TB] reset during SHOW of sel 5");
      waitFor("reach_sel5", 0, 5, 1'b0, 3'd0);
      doReset();
      repeat (3) applyStimulus(1'b0, 1'b0, 3'd0);
      releaseReset();
      repeat (20) applyStimulus(1'b0, 1'b0, 3'd0);

      $display("[TB] hold on map 3");
      waitFor("hold_sel5", 0, 5, 1'b0, 3'd0);
      repeat (30) applyStimulus(1'b1, 1'b1, 3'd3);
      repeat (30) applyStimulus(1'b1, 1'b0, 3'd3);

      $display("[TB] enable drop in BLANK and SHOW");
      waitFor("drop_blank", 1, 0, 1'b0, 3'd0);
      applyStimulus(1'b0, 1'b0, 3'd0);
      repeat (20) applyStimulus(1'b1, 1'b0, 3'd0);
      waitFor("drop_sel2", 0, 2, 1'b0, 3'd0);
      applyStimulus(1'b0, 1'b0, 3'd0);
      repeat (20) applyStimulus(1'b1, 1'b0, 3'd0);

      $display("[TB] random enable/hold/hold_sel");
      h  = 1'b0;
      hs = 3'd0;
      for (int n = 0; n < 10000; n++) begin
         en = ($urandom_range(0, 99) < 95);
         if ($urandom_range(0, 99) < 5) h = ~h;
         if ($urandom_range(0, 99) < 10) hs = 3'($urandom_range(0, 7));
         applyStimulus(en, h, hs);
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
